// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the commit-trace buffer: record type codes, FSM encoding and record width.
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        REC_RF   = 2'b00,
        REC_DM   = 2'b01,
        REC_HALT = 2'b10
    } rec_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_e;

    function automatic int rec_width(input int addr_w, input int data_w);
        return 2 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular record buffer with extra-MSB pointers; a full buffer either overwrites the oldest
// entry (WRAP=1) or drops the incoming one (WRAP=0), pulsing drop_o in both cases.
module trace_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 66,
    parameter int WRAP  = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       ready_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty, full, pop, wr_en;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && ready_i;

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        drop_o = 1'b0;
        wr_en  = 1'b0;
        if (pop) rd_d = rd_q + 1'b1;
        if (push_i) begin
            if (full && !pop) begin
                drop_o = 1'b1;
                // Overwrite mode advances both pointers so the oldest entry is discarded.
                if (WRAP != 0) begin
                    wr_en = 1'b1;
                    wr_d  = wr_q + 1'b1;
                    rd_d  = rd_q + 1'b1;
                end
            end else begin
                wr_en = 1'b1;
                wr_d  = wr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= data_i;
    end

    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign count_o = wr_q - rd_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Commit-trace capture: FSM, halt/timeout detection and record muxing into trace_fifo.
// Define TRACE_MEM_EN to also capture data-memory writes (type 01 records).
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int DEPTH       = 64,
    parameter int WRAP        = 1,
    parameter int HALT_CYCLES = 4,
    parameter int MAX_CYCLES  = 560,
    localparam int REC_W      = rec_width(ADDR_W, DATA_W)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [ADDR_W-1:0]      pc_i,
    input  logic                   rf_we_i,
    input  logic [REG_AW-1:0]      rf_addr_i,
    input  logic [DATA_W-1:0]      rf_data_i,
    input  logic                   dm_we_i,
    input  logic [ADDR_W-1:0]      dm_addr_i,
    input  logic [DATA_W-1:0]      dm_data_i,
    input  logic                   rd_ready_i,
    output logic                   rd_valid_o,
    output logic [REC_W-1:0]       rd_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [31:0]            cycle_o,
    output logic                   overflow_o,
    output logic                   halted_o,
    output logic                   timeout_o
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] prev_pc_q, prev_pc_d;
    logic [31:0]       stab_q, stab_d, cycle_q, cycle_d;
    logic              ovf_q, ovf_d, timeout_q, timeout_d;
    logic              push, conflict, drop, pc_same, halt_stable, hit_max;
    logic [1:0]        rec_type;
    logic [ADDR_W-1:0] rec_addr;
    logic [DATA_W-1:0] rec_data;

`ifndef TRACE_MEM_EN
    logic unused_dm;
    assign unused_dm = ^{dm_we_i, dm_addr_i, dm_data_i};
`endif

    assign pc_same     = (pc_i == prev_pc_q);
    assign halt_stable = pc_same && (stab_q == 32'(HALT_CYCLES - 1));
    assign hit_max     = (cycle_q == 32'(MAX_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        prev_pc_d = pc_i;
        stab_d    = stab_q;
        cycle_d   = cycle_q;
        timeout_d = timeout_q;
        push      = 1'b0;
        conflict  = 1'b0;
        rec_type  = REC_RF;
        rec_addr  = ADDR_W'(rf_addr_i);
        rec_data  = rf_data_i;
        case (state_q)
            IDLE: if (en_i) state_d = RUN;
            RUN: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else begin
                    cycle_d = (cycle_q == '1) ? cycle_q : cycle_q + 32'd1;
                    stab_d  = pc_same ? stab_q + 32'd1 : '0;
                    // The halt marker takes the slot of any write seen on the same edge.
                    if (halt_stable || hit_max) begin
                        state_d   = HALT;
                        timeout_d = hit_max;
                        push      = 1'b1;
                        rec_type  = REC_HALT;
                        rec_addr  = pc_i;
                        rec_data  = DATA_W'(cycle_q);
                    end else if (rf_we_i) begin
                        push = 1'b1;
`ifdef TRACE_MEM_EN
                        conflict = dm_we_i;
`endif
                    end
`ifdef TRACE_MEM_EN
                    else if (dm_we_i) begin
                        push     = 1'b1;
                        rec_type = REC_DM;
                        rec_addr = dm_addr_i;
                        rec_data = dm_data_i;
                    end
`endif
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        ovf_d = ovf_q | drop | conflict;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            prev_pc_q <= '0;
            stab_q    <= '0;
            cycle_q   <= '0;
            ovf_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_pc_q <= prev_pc_d;
            stab_q    <= stab_d;
            cycle_q   <= cycle_d;
            ovf_q     <= ovf_d;
            timeout_q <= timeout_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W),
        .WRAP  (WRAP)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  ({rec_type, rec_addr, rec_data}),
        .ready_i (rd_ready_i),
        .valid_o (rd_valid_o),
        .data_o  (rd_data_o),
        .count_o (count_o),
        .drop_o  (drop)
    );

    assign cycle_o    = cycle_q;
    assign overflow_o = ovf_q;
    assign halted_o   = (state_q == HALT);
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: two DEPTH=4 instances (overwrite and drop) share stimulus.
module tb_cpu_trace_buffer;
    localparam int RW = 66;

    logic        clk = 1'b0;
    logic        rst_i, en_i, rf_we_i, dm_we_i, rd_ready_i;
    logic [31:0] pc_i, rf_data_i, dm_addr_i, dm_data_i;
    logic [4:0]  rf_addr_i;

    logic          a_valid, a_ovf, a_halted, a_timeout;
    logic [RW-1:0] a_data;
    logic [2:0]    a_count;
    logic [31:0]   a_cycle;
    logic          b_valid, b_ovf, b_halted, b_timeout;
    logic [RW-1:0] b_data;
    logic [2:0]    b_count;
    logic [31:0]   b_cycle;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_trace_buffer #(.DEPTH(4), .WRAP(1), .HALT_CYCLES(4), .MAX_CYCLES(20)) dut_w (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pc_i(pc_i),
        .rf_we_i(rf_we_i), .rf_addr_i(rf_addr_i), .rf_data_i(rf_data_i),
        .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_data_i(dm_data_i),
        .rd_ready_i(rd_ready_i), .rd_valid_o(a_valid), .rd_data_o(a_data),
        .count_o(a_count), .cycle_o(a_cycle), .overflow_o(a_ovf),
        .halted_o(a_halted), .timeout_o(a_timeout)
    );

    cpu_trace_buffer #(.DEPTH(4), .WRAP(0), .HALT_CYCLES(4), .MAX_CYCLES(20)) dut_d (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pc_i(pc_i),
        .rf_we_i(rf_we_i), .rf_addr_i(rf_addr_i), .rf_data_i(rf_data_i),
        .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_data_i(dm_data_i),
        .rd_ready_i(rd_ready_i), .rd_valid_o(b_valid), .rd_data_o(b_data),
        .count_o(b_count), .cycle_o(b_cycle), .overflow_o(b_ovf),
        .halted_o(b_halted), .timeout_o(b_timeout)
    );

    function automatic logic [RW-1:0] rec(input logic [1:0] t, input logic [31:0] a,
                                          input logic [31:0] d);
        return {t, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0; en_i = 1'b0; pc_i = '0; rf_we_i = 1'b0; rf_addr_i = '0; rf_data_i = '0;
        dm_we_i = 1'b0; dm_addr_i = '0; dm_data_i = '0; rd_ready_i = 1'b0;
        tick();
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (10) tick();
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", a_valid); end
        total++; if (a_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", a_count); end
        total++; if (a_cycle !== 32'd0) begin bad++; $display("FAIL reset_cycle got=%0d want=0", a_cycle); end
        total++; if (a_halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0b want=0", a_halted); end
        total++; if (a_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", a_data); end
        total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", a_ovf); end
    endtask

    task automatic test_capture();
        do_reset();
        en_i = 1'b1; pc_i = 32'h100; rd_ready_i = 1'b1;
        tick();
        pc_i = 32'h104; rf_we_i = 1'b1; rf_addr_i = 5'd1; rf_data_i = 32'd5;
        tick();
        total++; if (a_valid !== 1'b1 || a_data !== rec(2'b00, 32'd1, 32'd5))
            begin bad++; $display("FAIL cap_r1 got=%h want=%h", a_data, rec(2'b00, 32'd1, 32'd5)); end
        pc_i = 32'h108; rf_addr_i = 5'd2; rf_data_i = 32'd7;
        tick();
        total++; if (a_data !== rec(2'b00, 32'd2, 32'd7))
            begin bad++; $display("FAIL cap_r2 got=%h want=%h", a_data, rec(2'b00, 32'd2, 32'd7)); end
        pc_i = 32'h10c; rf_addr_i = 5'd3; rf_data_i = 32'd12;
        tick();
        total++; if (a_data !== rec(2'b00, 32'd3, 32'd12) || a_count !== 3'd1)
            begin bad++; $display("FAIL cap_r3 got=%h/%0d want=%h/1", a_data, a_count, rec(2'b00, 32'd3, 32'd12)); end
        pc_i = 32'h110; rf_we_i = 1'b0;
        tick();
        total++; if (a_count !== 3'd0 || a_valid !== 1'b0)
            begin bad++; $display("FAIL cap_drain got=%0d/%0b want=0/0", a_count, a_valid); end
    endtask

    task automatic test_halt();
        do_reset();
        en_i = 1'b1; pc_i = 32'd0;
        tick();
        tick();
        pc_i = 32'd4;  tick();
        pc_i = 32'd8;  tick();
        pc_i = 32'd12; repeat (4) tick();
        total++; if (a_halted !== 1'b0) begin bad++; $display("FAIL halt_early got=%0b want=0", a_halted); end
        rf_we_i = 1'b1; rf_addr_i = 5'd9; rf_data_i = 32'd99;
        tick();
        total++; if (a_halted !== 1'b1) begin bad++; $display("FAIL halt_set got=%0b want=1", a_halted); end
        total++; if (a_data !== rec(2'b10, 32'd12, 32'd7) || a_count !== 3'd1)
            begin bad++; $display("FAIL halt_marker got=%h/%0d want=%h/1", a_data, a_count, rec(2'b10, 32'd12, 32'd7)); end
        total++; if (a_timeout !== 1'b0) begin bad++; $display("FAIL halt_timeout got=%0b want=0", a_timeout); end
        total++; if (a_cycle !== 32'd8) begin bad++; $display("FAIL halt_cycle got=%0d want=8", a_cycle); end
        repeat (3) tick();
        total++; if (a_count !== 3'd1) begin bad++; $display("FAIL halt_nocap got=%0d want=1", a_count); end
        rf_we_i = 1'b0; rd_ready_i = 1'b1;
        tick();
        total++; if (a_count !== 3'd0 || a_halted !== 1'b1)
            begin bad++; $display("FAIL halt_read got=%0d/%0b want=0/1", a_count, a_halted); end
    endtask

    task automatic test_overflow();
        do_reset();
        en_i = 1'b1; pc_i = 32'h200;
        tick();
        for (int i = 1; i <= 6; i++) begin
            pc_i = pc_i + 32'd4; rf_we_i = 1'b1; rf_addr_i = 5'(i); rf_data_i = 32'(i * 10);
            tick();
        end
        rf_we_i = 1'b0;
        total++; if (a_count !== 3'd4 || a_ovf !== 1'b1)
            begin bad++; $display("FAIL ovf_wrap got=%0d/%0b want=4/1", a_count, a_ovf); end
        total++; if (b_count !== 3'd4 || b_ovf !== 1'b1)
            begin bad++; $display("FAIL ovf_drop got=%0d/%0b want=4/1", b_count, b_ovf); end
        rd_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++; if (a_data !== rec(2'b00, 32'(3 + k), 32'((3 + k) * 10)))
                begin bad++; $display("FAIL ovf_wrap_rd%0d got=%h want=%h", k, a_data, rec(2'b00, 32'(3 + k), 32'((3 + k) * 10))); end
            total++; if (b_data !== rec(2'b00, 32'(1 + k), 32'((1 + k) * 10)))
                begin bad++; $display("FAIL ovf_drop_rd%0d got=%h want=%h", k, b_data, rec(2'b00, 32'(1 + k), 32'((1 + k) * 10))); end
            pc_i = pc_i + 32'd4;
            tick();
        end
        total++; if (a_count !== 3'd0 || b_count !== 3'd0)
            begin bad++; $display("FAIL ovf_empty got=%0d/%0d want=0/0", a_count, b_count); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        en_i = 1'b1; pc_i = 32'h300;
        tick();
        for (int i = 1; i <= 4; i++) begin
            pc_i = pc_i + 32'd4; rf_we_i = 1'b1; rf_addr_i = 5'(i); rf_data_i = 32'(i * 10);
            tick();
        end
        total++; if (a_count !== 3'd4 || a_ovf !== 1'b0)
            begin bad++; $display("FAIL full_fill got=%0d/%0b want=4/0", a_count, a_ovf); end
        pc_i = pc_i + 32'd4; rf_addr_i = 5'd5; rf_data_i = 32'd50; rd_ready_i = 1'b1;
        tick();
        rf_we_i = 1'b0; rd_ready_i = 1'b0;
        total++; if (a_count !== 3'd4 || a_ovf !== 1'b0 || a_data !== rec(2'b00, 32'd2, 32'd20))
            begin bad++; $display("FAIL full_pp_wrap got=%0d/%0b/%h want=4/0/%h", a_count, a_ovf, a_data, rec(2'b00, 32'd2, 32'd20)); end
        total++; if (b_count !== 3'd4 || b_ovf !== 1'b0 || b_data !== rec(2'b00, 32'd2, 32'd20))
            begin bad++; $display("FAIL full_pp_drop got=%0d/%0b/%h want=4/0/%h", b_count, b_ovf, b_data, rec(2'b00, 32'd2, 32'd20)); end
    endtask

    task automatic test_reset_midop();
        rst_i = 1'b0;
        #1;
        total++; if (a_count !== 3'd0 || a_valid !== 1'b0 || a_data !== '0)
            begin bad++; $display("FAIL midrst got=%0d/%0b/%h want=0/0/0", a_count, a_valid, a_data); end
        total++; if (a_cycle !== 32'd0 || b_count !== 3'd0)
            begin bad++; $display("FAIL midrst_cyc got=%0d/%0d want=0/0", a_cycle, b_count); end
        tick();
        rst_i = 1'b1;
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        en_i = 1'b1; pc_i = 32'd0;
        tick();
        n = 0;
        pc_i = 32'd4;
        while (!a_halted && n < 40) begin
            tick();
            n++;
            if (!a_halted) pc_i = pc_i + 32'd4;
        end
        total++; if (n !== 20) begin bad++; $display("FAIL to_cycles got=%0d want=20", n); end
        total++; if (a_timeout !== 1'b1 || a_halted !== 1'b1)
            begin bad++; $display("FAIL to_flag got=%0b/%0b want=1/1", a_timeout, a_halted); end
        total++; if (a_data !== rec(2'b10, 32'd80, 32'd19))
            begin bad++; $display("FAIL to_marker got=%h want=%h", a_data, rec(2'b10, 32'd80, 32'd19)); end
        total++; if (a_cycle !== 32'd20) begin bad++; $display("FAIL to_cycle_o got=%0d want=20", a_cycle); end
    endtask

    task automatic test_mem();
        logic [2:0] c1, c2;
        logic       o2;
`ifdef TRACE_MEM_EN
        c1 = 3'd1; c2 = 3'd2; o2 = 1'b1;
`else
        c1 = 3'd0; c2 = 3'd1; o2 = 1'b0;
`endif
        do_reset();
        en_i = 1'b1; pc_i = 32'd0;
        tick();
        pc_i = 32'd4; dm_we_i = 1'b1; dm_addr_i = 32'd16; dm_data_i = 32'd9;
        tick();
        dm_we_i = 1'b0;
        total++; if (a_count !== c1) begin bad++; $display("FAIL mem_count got=%0d want=%0d", a_count, c1); end
`ifdef TRACE_MEM_EN
        total++; if (a_data !== rec(2'b01, 32'd16, 32'd9))
            begin bad++; $display("FAIL mem_rec got=%h want=%h", a_data, rec(2'b01, 32'd16, 32'd9)); end
`else
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL mem_ignored got=%0b want=0", a_valid); end
`endif
        pc_i = 32'd8; rf_we_i = 1'b1; rf_addr_i = 5'd2; rf_data_i = 32'd3; dm_we_i = 1'b1;
        tick();
        rf_we_i = 1'b0; dm_we_i = 1'b0;
        total++; if (a_count !== c2 || a_ovf !== o2)
            begin bad++; $display("FAIL mem_conflict got=%0d/%0b want=%0d/%0b", a_count, a_ovf, c2, o2); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_halt();
        test_overflow();
        test_full_push_pop();
        test_reset_midop();
        test_timeout();
        test_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
